// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, byte-slice addressing and the
// SubBytes sequencer states.
package aes_pkg;

    localparam int unsigned STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // Byte 0 is the most significant byte, so its LSB sits at bit 120.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle between the round datapath, sub_bytes_iter and ShiftRows.
interface sub_bytes_iter_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] state_in;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;
    logic               busy;

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational; shared with key expansion.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes per cycle in place, then
// holds the finished state for ShiftRows until it is consumed.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    sub_bytes_iter_if.slave  bus
);

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, data_d;

    logic [7:0] sb_in  [LANES];
    logic [7:0] sb_out [LANES];

    function automatic logic [3:0] lane_byte(input logic [CNT_W-1:0] c, input int unsigned l);
        int unsigned t;
        t = 32'(c) * LANES + l;
        return t[3:0];
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sb_in[l]),
            .out_byte (sb_out[l])
        );
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            sb_in[l] = data_q[byte_lsb(lane_byte(cnt_q, l)) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // cnt parks on its last value through DONE and clears on leaving it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.state_in;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    data_d[byte_lsb(lane_byte(cnt_q, l)) +: 8] = sb_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == SUB) || (state_q == DONE);
    end

    assign bus.state_out = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench: one DUT per legal LANES value; index 2 (LANES=4) is the main one.
module tb_sub_bytes_iter;

    localparam int unsigned N = 5;
    localparam int unsigned MAIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] iv;
    logic [N-1:0] ordy;
    logic [127:0] sin  [N];
    logic [N-1:0] ir;
    logic [N-1:0] ov;
    logic [N-1:0] bz;
    logic [127:0] sout [N];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sub_bytes_iter_if bus ();
        sub_bytes_iter #(.LANES(32'(1 << g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid  = iv[g];
        assign bus.state_in  = sin[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]   = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign bz[g]   = bus.busy;
        assign sout[g] = bus.state_out;
    end

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ONES_OUT = 128'h16161616161616161616161616161616;
    localparam logic [127:0] S53_IN   = 128'h53535353535353535353535353535353;
    localparam logic [127:0] S53_OUT  = 128'hedededededededededededededededed;

    // Present a block, wait for acceptance, then wait for out_valid and check.
    task automatic send(input int k, input logic [127:0] d, input logic [127:0] exp,
                        input int lat_exp, input string name);
        int n;
        sin[k] = d;
        iv[k]  = 1'b1;
        n = 0;
        while (!ir[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
        n = 0;
        while (!ov[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n !== lat_exp) begin
            errors++;
            $display("FAIL %s latency lanes_idx=%0d: got %0d want %0d", name, k, n, lat_exp);
        end
        checks++;
        if (sout[k] !== exp) begin
            errors++;
            $display("FAIL %s data lanes_idx=%0d: got %h want %h", name, k, sout[k], exp);
        end
    endtask

    task automatic complete(input int k, input string name);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake lanes_idx=%0d: got ov=%b ir=%b want ov=0 ir=1", name, k, ov[k], ir[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ir !== 5'h1f || ov !== 5'h00 || bz !== 5'h00) begin
            errors++;
            $display("FAIL reset flags: got ir=%b ov=%b busy=%b want 11111 00000 00000", ir, ov, bz);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sout[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset state_out idx=%0d: got %h want 0", i, sout[i]);
            end
        end
    endtask

    task automatic test_fips();
        send(MAIN, FIPS_IN, FIPS_OUT, 4, "fips");
        complete(MAIN, "fips");
    endtask

    task automatic test_edge_values();
        for (int k = 0; k < N; k++) begin
            send(k, 128'h0, ZERO_OUT, 16 >> k, "zeros");
            complete(k, "zeros");
            send(k, {16{8'hff}}, ONES_OUT, 16 >> k, "ones");
            complete(k, "ones");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        int bad;
        ordy[MAIN] = 1'b0;
        send(MAIN, FIPS_IN, FIPS_OUT, 4, "bp_first");
        held = sout[MAIN];
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov[MAIN] !== 1'b1 || ir[MAIN] !== 1'b0 || sout[MAIN] !== held) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (last ov=%b ir=%b out=%h)",
                     bad, ov[MAIN], ir[MAIN], sout[MAIN]);
        end
        complete(MAIN, "bp_release");
        send(MAIN, SEQ_IN, SEQ_OUT, 4, "bp_next");
        complete(MAIN, "bp_next");
    endtask

    task automatic test_in_valid_busy();
        int n;
        int bad;
        ordy[MAIN] = 1'b0;
        sin[MAIN]  = SEQ_IN;
        iv[MAIN]   = 1'b1;
        @(posedge clk); #1;
        sin[MAIN] = FIPS_IN;
        n = 0;
        bad = 0;
        while (!ov[MAIN] && n < 200) begin
            if (ir[MAIN] !== 1'b0) bad++;
            @(posedge clk); #1; n++;
        end
        repeat (2) begin
            if (ir[MAIN] !== 1'b0 || ov[MAIN] !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0 || n != 4) begin
            errors++;
            $display("FAIL ivbusy_block: got %0d bad cycles latency %0d want 0 and 4", bad, n);
        end
        checks++;
        if (sout[MAIN] !== SEQ_OUT) begin
            errors++;
            $display("FAIL ivbusy_first: got %h want %h", sout[MAIN], SEQ_OUT);
        end
        ordy[MAIN] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[MAIN] !== 1'b0 || ir[MAIN] !== 1'b1) begin
            errors++;
            $display("FAIL ivbusy_hs: got ov=%b ir=%b want ov=0 ir=1", ov[MAIN], ir[MAIN]);
        end
        @(posedge clk); #1;
        iv[MAIN] = 1'b0;
        checks++;
        if (bz[MAIN] !== 1'b1 || ir[MAIN] !== 1'b0) begin
            errors++;
            $display("FAIL ivbusy_accept2: got busy=%b ir=%b want busy=1 ir=0", bz[MAIN], ir[MAIN]);
        end
        n = 0;
        while (!ov[MAIN] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (sout[MAIN] !== FIPS_OUT || n != 4) begin
            errors++;
            $display("FAIL ivbusy_second: got %h lat %0d want %h lat 4", sout[MAIN], n, FIPS_OUT);
        end
        complete(MAIN, "ivbusy_second");
    endtask

    task automatic test_reset_mid();
        int bad;
        ordy[MAIN] = 1'b1;
        sin[MAIN]  = S53_IN;
        iv[MAIN]   = 1'b1;
        @(posedge clk); #1;
        iv[MAIN] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ir[MAIN] !== 1'b1 || ov[MAIN] !== 1'b0 || bz[MAIN] !== 1'b0 || sout[MAIN] !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_state: got ir=%b ov=%b busy=%b out=%h want 1 0 0 0",
                     ir[MAIN], ov[MAIN], bz[MAIN], sout[MAIN]);
        end
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov[MAIN] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_output: got %0d cycles with out_valid want 0", bad);
        end
        send(MAIN, S53_IN, S53_OUT, 4, "rstmid_after");
        complete(MAIN, "rstmid_after");
    endtask

    initial begin
        iv   = '0;
        ordy = '1;
        for (int i = 0; i < N; i++) sin[i] = '0;
        test_reset();
        test_fips();
        test_edge_values();
        test_backpressure();
        test_in_valid_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
